adc_gain_select: RTL and testbench



---
 rtl/adc_gain_select.sv | 141 ++++++++++++++
 tb/tb_adc_gain_select.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_gain_select.sv
// Merges the dual high/low-gain ADC streams into one tagged 13-bit stream.
// Samples from PRE before a high-gain saturation to WIN after it are taken from the low-gain ADC.
module adc_gain_select #(
    parameter int               WIDTH  = 12,
    parameter logic [WIDTH-1:0] SatThr = 12'hFFF,
    parameter int               PRE    = 3,
    parameter int               WIN    = 8
) (
    input  logic             ClkIn,
    input  logic             rst,
    input  logic             DinValid,
    input  logic [WIDTH-1:0] DinH,
    input  logic [WIDTH-1:0] DinL,
    input  logic             OvfH,
    input  logic [1:0]       CalBusy,
    input  logic             SatCntClr,
    output logic             DoutValid,
    output logic [WIDTH:0]   DataOut,
    output logic [15:0]      SatCount
);

    localparam int CNT_W  = $clog2(PRE + WIN + 1);
    localparam int FILL_W = $clog2(PRE + 1);

    localparam logic [CNT_W-1:0]  CntLoad  = CNT_W'(PRE + WIN);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CntZero  = CNT_W'(0);
    localparam logic [FILL_W-1:0] FillFull = FILL_W'(PRE);
    localparam logic [FILL_W-1:0] FillOne  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FillZero = FILL_W'(0);

    function automatic logic isSat(input logic ovf, input logic [WIDTH-1:0] hi);
        return ovf | (hi >= SatThr);
    endfunction

    logic [2*WIDTH-1:0] dlyLine_r [PRE];
    logic [CNT_W-1:0]   cnt_r;
    logic [FILL_W-1:0]  fill_r;
    logic               doutValid_r;
    logic [WIDTH:0]     dataOut_r;
    logic [15:0]        satCount_r;

    logic               accept_s;
    logic               calActive_s;
    logic               sat_s;
    logic               sel_s;
    logic               newWin_s;
    logic [2*WIDTH-1:0] oldest_s;
    logic [WIDTH:0]     muxWord_s;

    // Acceptance, saturation detect and the gain-select mux.
    always_comb begin
        calActive_s = (CalBusy != 2'b00);
        accept_s    = DinValid & ~calActive_s;
        sat_s       = isSat(OvfH, DinH);
        sel_s       = sat_s | (cnt_r != CntZero);
        newWin_s    = sat_s & (cnt_r == CntZero);
        oldest_s    = dlyLine_r[PRE-1];
        if (sel_s) begin
            muxWord_s = {1'b1, oldest_s[WIDTH-1:0]};
        end else begin
            muxWord_s = {1'b0, oldest_s[2*WIDTH-1:WIDTH]};
        end
    end

    // Pre-trigger delay line of {high, low} sample pairs; calibration flushes it.
    always_ff @(posedge ClkIn) begin
        if (rst || calActive_s) begin
            for (int i = 0; i < PRE; i++) begin
                dlyLine_r[i] <= '0;
            end
        end else if (accept_s) begin
            dlyLine_r[0] <= {DinH, DinL};
            for (int i = 1; i < PRE; i++) begin
                dlyLine_r[i] <= dlyLine_r[i-1];
            end
        end else begin
            for (int i = 0; i < PRE; i++) begin
                dlyLine_r[i] <= dlyLine_r[i];
            end
        end
    end

    // Low-gain window counter; a saturation inside a window reloads it.
    always_ff @(posedge ClkIn) begin
        if (rst || calActive_s) begin
            cnt_r <= CntZero;
        end else if (accept_s) begin
            if (sat_s) begin
                cnt_r <= CntLoad;
            end else if (cnt_r != CntZero) begin
                cnt_r <= cnt_r - CntOne;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Fill counter: output stays invalid until the delay line holds real samples.
    always_ff @(posedge ClkIn) begin
        if (rst || calActive_s) begin
            fill_r <= FillZero;
        end else if (accept_s && (fill_r != FillFull)) begin
            fill_r <= fill_r + FillOne;
        end else begin
            fill_r <= fill_r;
        end
    end

    // Registered output word; DataOut keeps its last value between valid words.
    always_ff @(posedge ClkIn) begin
        if (rst) begin
            doutValid_r <= 1'b0;
            dataOut_r   <= '0;
        end else if (accept_s && (fill_r == FillFull)) begin
            doutValid_r <= 1'b1;
            dataOut_r   <= muxWord_s;
        end else begin
            doutValid_r <= 1'b0;
            dataOut_r   <= dataOut_r;
        end
    end

    // Count of opened windows, saturating; clear beats a simultaneous increment.
    always_ff @(posedge ClkIn) begin
        if (rst || SatCntClr) begin
            satCount_r <= 16'd0;
        end else if (accept_s && newWin_s && (satCount_r != 16'hFFFF)) begin
            satCount_r <= satCount_r + 16'd1;
        end else begin
            satCount_r <= satCount_r;
        end
    end

    assign DoutValid = doutValid_r;
    assign DataOut   = dataOut_r;
    assign SatCount  = satCount_r;

endmodule

// File: tb/tb_adc_gain_select.sv
// Self-checking bench for adc_gain_select: window-based reference model plus directed literals.
module tb_adc_gain_select;

    localparam int PRE = 3;
    localparam int WIN = 8;

    logic        ClkIn = 1'b0;
    logic        rst = 1'b1;
    logic        DinValid = 1'b0;
    logic [11:0] DinH = 12'd0;
    logic [11:0] DinL = 12'd0;
    logic        OvfH = 1'b0;
    logic [1:0]  CalBusy = 2'b00;
    logic        SatCntClr = 1'b0;
    logic        DoutValid;
    logic [12:0] DataOut;
    logic [15:0] SatCount;

    adc_gain_select dut (
        .ClkIn(ClkIn), .rst(rst), .DinValid(DinValid), .DinH(DinH), .DinL(DinL),
        .OvfH(OvfH), .CalBusy(CalBusy), .SatCntClr(SatCntClr),
        .DoutValid(DoutValid), .DataOut(DataOut), .SatCount(SatCount)
    );

    always #5 ClkIn = ~ClkIn;

    int checks = 0;
    int errors = 0;
    bit chkEn = 1'b0;
    int cycle = 0;

    // Model: samples accepted since the last reset/calibration
    bit          satQ[$];
    logic [11:0] hQ[$];
    logic [11:0] lQ[$];
    logic        expV = 1'b0;
    logic [12:0] expD = 13'd0;
    logic [15:0] expC = 16'd0;

    // Per-cycle compare against the model
    always begin
        @(posedge ClkIn);
        #1;
        cycle++;
        if (chkEn) begin
            checks++;
            if (DoutValid !== expV || DataOut !== expD || SatCount !== expC) begin
                errors++;
                $display("FAIL model cycle %0d: got V=%b D=%h C=%0d, expected V=%b D=%h C=%0d",
                         cycle, DoutValid, DataOut, SatCount, expV, expD, expC);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelUpdate(input bit r, input bit v, input logic [11:0] h, input logic [11:0] l,
                               input bit ovf, input logic [1:0] cal, input bit clr);
        int  n;
        int  s;
        bit  sat;
        bit  newWin;
        bit  low;
        if (r) begin
            satQ.delete(); hQ.delete(); lQ.delete();
            expV = 1'b0; expD = 13'd0; expC = 16'd0;
        end else begin
            if (cal != 2'b00) begin
                satQ.delete(); hQ.delete(); lQ.delete();
                expV = 1'b0;
            end else if (v) begin
                sat = ovf || (h >= 12'hFFF);
                satQ.push_back(sat); hQ.push_back(h); lQ.push_back(l);
                n = satQ.size() - 1;
                newWin = sat;
                for (int j = n - PRE - WIN; j < n; j++)
                    if (j >= 0 && satQ[j]) newWin = 1'b0;
                if (newWin && expC != 16'hFFFF) expC = expC + 16'd1;
                if (n >= PRE) begin
                    s = n - PRE;
                    low = 1'b0;
                    for (int j = s - WIN; j <= n; j++)
                        if (j >= 0 && satQ[j]) low = 1'b1;
                    expV = 1'b1;
                    expD = low ? {1'b1, lQ[s]} : {1'b0, hQ[s]};
                end else begin
                    expV = 1'b0;
                end
            end else begin
                expV = 1'b0;
            end
            if (clr) expC = 16'd0;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [11:0] h, input logic [11:0] l,
                        input bit ovf, input logic [1:0] cal, input bit clr);
        @(negedge ClkIn);
        rst = r; DinValid = v; DinH = h; DinL = l; OvfH = ovf; CalBusy = cal; SatCntClr = clr;
        modelUpdate(r, v, h, l, ovf, cal, clr);
        @(posedge ClkIn);
        #2;
    endtask

    task automatic runDirected(input bit gaps);
        logic [11:0] h;
        bit          ovf;
        for (int k = 0; k < 90; k++) begin
            if (gaps) step(1'b0, 1'b0, 12'($urandom), 12'($urandom), 1'($urandom), 2'b00, 1'b0);
            h = 12'(k);
            ovf = 1'b0;
            if (k == 10 || k == 60 || k == 65) h = 12'hFFF;
            if (k == 40) begin h = 12'h800; ovf = 1'b1; end
            step(1'b0, 1'b1, h, 12'(100 + k), ovf, 2'b00, 1'b0);
            case (k)
                2:  chk("fill_not_valid", {31'd0, DoutValid}, 32'd0);
                3:  begin chk("first_valid", {31'd0, DoutValid}, 32'd1);
                          chk("first_word", {19'd0, DataOut}, 32'h0000); end
                9:  begin chk("sample6_high", {19'd0, DataOut}, 32'h0006);
                          chk("no_sat_count", {16'd0, SatCount}, 32'd0); end
                10: begin chk("sample7_low", {19'd0, DataOut}, 32'h1000 + 32'd107);
                          chk("sat_count1", {16'd0, SatCount}, 32'd1); end
                21: chk("sample18_low", {19'd0, DataOut}, 32'h1000 + 32'd118);
                22: chk("sample19_high", {19'd0, DataOut}, 32'd19);
                39: chk("sample36_high", {19'd0, DataOut}, 32'd36);
                40: begin chk("ovf_sample37_low", {19'd0, DataOut}, 32'h1000 + 32'd137);
                          chk("ovf_count2", {16'd0, SatCount}, 32'd2); end
                51: chk("ovf_sample48_low", {19'd0, DataOut}, 32'h1000 + 32'd148);
                52: chk("ovf_sample49_high", {19'd0, DataOut}, 32'd49);
                59: chk("merge_sample56_high", {19'd0, DataOut}, 32'd56);
                60: chk("merge_sample57_low", {19'd0, DataOut}, 32'h1000 + 32'd157);
                66: chk("merge_sample63_low", {19'd0, DataOut}, 32'h1000 + 32'd163);
                68: chk("merge_count3", {16'd0, SatCount}, 32'd3);
                76: chk("merge_sample73_low", {19'd0, DataOut}, 32'h1000 + 32'd173);
                77: chk("merge_sample74_high", {19'd0, DataOut}, 32'd74);
                default: ;
            endcase
        end
    endtask

    initial begin
        int calLeft;
        bit r, v, ovf, clr;
        logic [1:0]  cal;
        logic [11:0] h;

        step(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 2'b00, 1'b0);
        chkEn = 1'b1;
        step(1'b1, 1'b1, 12'hFFF, 12'd5, 1'b1, 2'b00, 1'b0);
        chk("reset_valid", {31'd0, DoutValid}, 32'd0);
        chk("reset_data", {19'd0, DataOut}, 32'd0);
        chk("reset_count", {16'd0, SatCount}, 32'd0);

        runDirected(1'b0);

        // Saturation followed by calibration: the pending window must be cancelled
        step(1'b0, 1'b1, 12'hFFF, 12'd190, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 12'd1, 12'd2, 1'b0, 2'b01, 1'b0);
            chk("cal_busy_invalid", {31'd0, DoutValid}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 12'(200 + i), 12'(300 + i), 1'b0, 2'b00, 1'b0);
            if (i < 3) chk("cal_refill_invalid", {31'd0, DoutValid}, 32'd0);
        end
        chk("cal_refill_valid", {31'd0, DoutValid}, 32'd1);
        chk("cal_window_cancelled", {19'd0, DataOut}, 32'd200);

        step(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 2'b00, 1'b0);
        runDirected(1'b1);

        step(1'b0, 1'b1, 12'hFFF, 12'd0, 1'b0, 2'b00, 1'b1);
        chk("clear_beats_incr", {16'd0, SatCount}, 32'd0);

        calLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 3) != 0);
            h   = ($urandom_range(0, 19) == 0) ? 12'hFFF : 12'($urandom);
            ovf = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 49) == 0);
            if (calLeft == 0 && $urandom_range(0, 99) == 0) calLeft = $urandom_range(1, 6);
            if (calLeft > 0) begin
                cal = 2'($urandom_range(1, 3));
                calLeft--;
            end else begin
                cal = 2'b00;
            end
            step(r, v, h, 12'($urandom), ovf, cal, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
